// File: rtl/decode_stage_pipe.sv
// -----------------------------------------------------------------------------
// decode_stage_pipe
//
// Instruction-decode stage for the RISC pipeline. It holds the general register
// file and the ID/EX pipeline register. A small FSM assembles two-word
// (LDM-class) instructions. The header word is captured first and the bundle
// issues when the immediate word arrives. Load-use stalls and flushes from the
// hazard/control logic are also handled here.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   instr_in            instruction or immediate word from IF/ID
//   instr_valid         instr_in carries a real word this cycle
//   load_use            hazard stall request (bubble, hold fetch)
//   flush               squash request (branch taken, interrupt, ret/rti)
//   wb_en/addr/data     register write-back port from WB
//   fetch_hold          hold PC and IF/ID this cycle (follows load_use)
//   imm_pending         FSM is waiting for an immediate word
//   ex_*                registered operand bundle for EX, qualified by ex_valid
//
// Build option
//   DECODE_WB_BYPASS_EN  when defined, a read port whose address matches an
//                        active write-back returns wb_data in the same cycle.
//                        When undefined, the new value is visible one cycle
//                        later.
// -----------------------------------------------------------------------------
module decode_stage_pipe #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int RA_W  = $clog2(NREGS),
    parameter int OPC_W = 5,
    parameter logic [OPC_W-1:0] IMM_OPC = 5'b11000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] instr_in,
    input  logic             instr_valid,
    input  logic             load_use,
    input  logic             flush,
    input  logic             wb_en,
    input  logic [RA_W-1:0]  wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             fetch_hold,
    output logic             imm_pending,
    output logic             ex_valid,
    output logic [OPC_W-1:0] ex_opcode,
    output logic [RA_W-1:0]  ex_src_addr,
    output logic [RA_W-1:0]  ex_dst_addr,
    output logic [WIDTH-1:0] ex_op1,
    output logic [WIDTH-1:0] ex_op2,
    output logic [WIDTH-1:0] ex_imm,
    output logic [7:0]       ex_shamt,
    output logic             ex_is_imm
);

    typedef enum logic {
        DECODE = 1'b0,
        IMM    = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] regs [NREGS];

    // Field decode of the incoming word
    logic [OPC_W-1:0] dec_opcode;
    logic [RA_W-1:0]  dec_rs;
    logic [RA_W-1:0]  dec_rd;
    logic [7:0]       dec_shamt;

    assign dec_opcode = instr_in[WIDTH-1 -: OPC_W];
    assign dec_rs     = instr_in[WIDTH-OPC_W-1 -: RA_W];
    assign dec_rd     = instr_in[WIDTH-OPC_W-RA_W-1 -: RA_W];
    assign dec_shamt  = instr_in[7:0];

    // Header of a two-word instruction. Only addresses and static fields are
    // kept. Operands are re-read when the immediate arrives, so a write-back
    // landing during the wait is picked up.
    logic [OPC_W-1:0] hdr_opcode;
    logic [RA_W-1:0]  hdr_rs;
    logic [RA_W-1:0]  hdr_rd;
    logic [7:0]       hdr_shamt;

    // Read ports: decode addresses in DECODE, latched addresses in IMM
    logic [RA_W-1:0]  addr_a;
    logic [RA_W-1:0]  addr_b;
    logic signed [WIDTH-1:0] rdata_a;
    logic signed [WIDTH-1:0] rdata_b;

    assign addr_a = (state == IMM) ? hdr_rs : dec_rs;
    assign addr_b = (state == IMM) ? hdr_rd : dec_rd;

`ifdef DECODE_WB_BYPASS_EN
    function automatic logic [WIDTH-1:0] read_port(
        input logic [WIDTH-1:0] stored,
        input logic [RA_W-1:0]  addr,
        input logic             we,
        input logic [RA_W-1:0]  waddr,
        input logic [WIDTH-1:0] wdata
    );
        if (we && (waddr == addr)) begin
            return wdata;
        end
        return stored;
    endfunction

    assign rdata_a = read_port(regs[addr_a], addr_a, wb_en, wb_addr, wb_data);
    assign rdata_b = read_port(regs[addr_b], addr_b, wb_en, wb_addr, wb_data);
`else
    assign rdata_a = regs[addr_a];
    assign rdata_b = regs[addr_b];
`endif

    // Control decode
    logic accept;
    logic issue_plain;
    logic issue_imm;
    logic capture;

    // A word is consumed only when it is real and neither stall nor flush is active
    assign accept = instr_valid & ~load_use & ~flush;

    always_comb begin
        state_nxt   = state;
        issue_plain = 1'b0;
        issue_imm   = 1'b0;
        capture     = 1'b0;
        if (flush) begin
            state_nxt = DECODE;
        end else if (accept) begin
            case (state)
                DECODE: begin
                    if (dec_opcode == IMM_OPC) begin
                        capture   = 1'b1;
                        state_nxt = IMM;
                    end else begin
                        issue_plain = 1'b1;
                    end
                end
                IMM: begin
                    issue_imm = 1'b1;
                    state_nxt = DECODE;
                end
                default: state_nxt = DECODE;
            endcase
        end
    end

    assign fetch_hold  = load_use;
    assign imm_pending = (state == IMM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DECODE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            hdr_opcode <= dec_opcode;
            hdr_rs     <= dec_rs;
            hdr_rd     <= dec_rd;
            hdr_shamt  <= dec_shamt;
        end
    end

    // ---- ID/EX boundary (stage p1) ----
    logic                    vld_p1;
    logic [OPC_W-1:0]        opcode_p1;
    logic [RA_W-1:0]         src_p1;
    logic [RA_W-1:0]         dst_p1;
    logic signed [WIDTH-1:0] op1_p1;
    logic signed [WIDTH-1:0] op2_p1;
    logic signed [WIDTH-1:0] imm_p1;
    logic [7:0]              shamt_p1;
    logic                    is_imm_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            opcode_p1 <= '0;
            src_p1    <= '0;
            dst_p1    <= '0;
            op1_p1    <= '0;
            op2_p1    <= '0;
            imm_p1    <= '0;
            shamt_p1  <= '0;
            is_imm_p1 <= 1'b0;
        end else begin
            vld_p1 <= issue_plain | issue_imm;
            if (flush) begin
                is_imm_p1 <= 1'b0;
            end else if (issue_plain) begin
                opcode_p1 <= dec_opcode;
                src_p1    <= dec_rs;
                dst_p1    <= dec_rd;
                op1_p1    <= rdata_a;
                op2_p1    <= rdata_b;
                imm_p1    <= '0;
                shamt_p1  <= dec_shamt;
                is_imm_p1 <= 1'b0;
            end else if (issue_imm) begin
                opcode_p1 <= hdr_opcode;
                src_p1    <= hdr_rs;
                dst_p1    <= hdr_rd;
                op1_p1    <= rdata_a;
                op2_p1    <= rdata_b;
                imm_p1    <= instr_in;
                shamt_p1  <= hdr_shamt;
                is_imm_p1 <= 1'b1;
            end
        end
    end

    assign ex_valid    = vld_p1;
    assign ex_opcode   = opcode_p1;
    assign ex_src_addr = src_p1;
    assign ex_dst_addr = dst_p1;
    assign ex_op1      = op1_p1;
    assign ex_op2      = op2_p1;
    assign ex_imm      = imm_p1;
    assign ex_shamt    = shamt_p1;
    assign ex_is_imm   = is_imm_p1;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// -----------------------------------------------------------------------------
// Testbench for decode_stage_pipe: default 16-bit/8-register instance plus a
// 32-bit/16-register instance for the parametrised build.
// -----------------------------------------------------------------------------
module tb_decode_stage_pipe;

    localparam logic [4:0] IMM = 5'b11000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_in;
    logic        instr_valid, load_use, flush, wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        fetch_hold, imm_pending, ex_valid, ex_is_imm;
    logic [4:0]  ex_opcode;
    logic [2:0]  ex_src_addr, ex_dst_addr;
    logic [15:0] ex_op1, ex_op2, ex_imm;
    logic [7:0]  ex_shamt;

    logic [31:0] p_instr;
    logic        p_valid, p_wb_en;
    logic [3:0]  p_wb_addr;
    logic [31:0] p_wb_data;
    logic        p_fetch_hold, p_imm_pending, p_ex_valid, p_ex_is_imm;
    logic [4:0]  p_ex_opcode;
    logic [3:0]  p_ex_src_addr, p_ex_dst_addr;
    logic [31:0] p_ex_op1, p_ex_op2, p_ex_imm;
    logic [7:0]  p_ex_shamt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_stage_pipe dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
        .load_use(load_use), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .fetch_hold(fetch_hold), .imm_pending(imm_pending),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_src_addr(ex_src_addr),
        .ex_dst_addr(ex_dst_addr), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_imm(ex_imm), .ex_shamt(ex_shamt), .ex_is_imm(ex_is_imm)
    );

    decode_stage_pipe #(.WIDTH(32), .NREGS(16)) dut_p (
        .clk(clk), .rst(rst), .instr_in(p_instr), .instr_valid(p_valid),
        .load_use(1'b0), .flush(1'b0), .wb_en(p_wb_en), .wb_addr(p_wb_addr),
        .wb_data(p_wb_data), .fetch_hold(p_fetch_hold), .imm_pending(p_imm_pending),
        .ex_valid(p_ex_valid), .ex_opcode(p_ex_opcode), .ex_src_addr(p_ex_src_addr),
        .ex_dst_addr(p_ex_dst_addr), .ex_op1(p_ex_op1), .ex_op2(p_ex_op2),
        .ex_imm(p_ex_imm), .ex_shamt(p_ex_shamt), .ex_is_imm(p_ex_is_imm)
    );

    // ---------------- behavioural reference model (default instance) --------
    logic [15:0] mregs [8];
    bit          m_pend, m_valid, m_isimm;
    logic [4:0]  m_opc, h_opc;
    logic [2:0]  m_rs, m_rd, h_rs, h_rd;
    logic [15:0] m_op1, m_op2, m_imm;
    logic [7:0]  m_sh, h_sh;

    function automatic logic [15:0] mread(input logic [2:0] a);
        logic [15:0] v;
        v = mregs[a];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && wb_addr == a) v = wb_data;
`endif
        return v;
    endfunction

    always @(posedge clk) begin : model
        if (rst) begin
            for (int i = 0; i < 8; i++) mregs[i] = '0;
            m_pend = 0; m_valid = 0; m_isimm = 0;
            m_opc = 0; m_rs = 0; m_rd = 0; m_op1 = 0; m_op2 = 0; m_imm = 0; m_sh = 0;
        end else begin
            m_valid = 0;
            if (flush) begin
                m_pend  = 0;
                m_isimm = 0;
            end else if (instr_valid && !load_use) begin
                if (m_pend) begin
                    m_opc = h_opc; m_rs = h_rs; m_rd = h_rd; m_sh = h_sh;
                    m_op1 = mread(h_rs); m_op2 = mread(h_rd);
                    m_imm = instr_in; m_isimm = 1; m_valid = 1; m_pend = 0;
                end else if (instr_in[15:11] == IMM) begin
                    h_opc = instr_in[15:11]; h_rs = instr_in[10:8];
                    h_rd = instr_in[7:5]; h_sh = instr_in[7:0];
                    m_pend = 1;
                end else begin
                    m_opc = instr_in[15:11]; m_rs = instr_in[10:8]; m_rd = instr_in[7:5];
                    m_sh = instr_in[7:0];
                    m_op1 = mread(instr_in[10:8]); m_op2 = mread(instr_in[7:5]);
                    m_imm = 0; m_isimm = 0; m_valid = 1;
                end
            end
            if (wb_en) mregs[wb_addr] = wb_data;
        end
    end

    // ---------------- helpers ----------------------------------------------
    function automatic logic [15:0] mk(input logic [4:0] o, input logic [2:0] s,
                                       input logic [2:0] d, input logic [4:0] lo);
        return {o, s, d, lo};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [15:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        step();
        wb_en = 1'b0;
    endtask

    // ---------------- tests --------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; load_use = 1'b1;
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
        checks++; if (imm_pending !== 1'b0) begin errors++; $display("FAIL reset_imm_pending got=%b exp=0", imm_pending); end
        checks++; if ({ex_op1, ex_op2, ex_imm, ex_is_imm} !== 49'd0) begin errors++; $display("FAIL reset_ex_fields got=%h %h %h %b exp=0", ex_op1, ex_op2, ex_imm, ex_is_imm); end
        checks++; if (fetch_hold !== 1'b1) begin errors++; $display("FAIL reset_fetch_hold got=%b exp=1", fetch_hold); end
        load_use = 1'b0;
        #1;
        checks++; if (fetch_hold !== 1'b0) begin errors++; $display("FAIL reset_fetch_hold_low got=%b exp=0", fetch_hold); end
        @(negedge clk);
        rst = 1'b0;
        instr_in = mk(5'd1, 3'd1, 3'd2, 5'd0); instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        checks++; if ({ex_valid, ex_op1, ex_op2} !== {1'b1, 32'd0}) begin errors++; $display("FAIL reset_regfile_zero got v=%b %h %h exp v=1 0 0", ex_valid, ex_op1, ex_op2); end
    endtask

    task automatic test_single_decode();
        wb_write(3'd3, 16'h1234);
        wb_write(3'd5, 16'h00FF);
        instr_in = mk(5'b00010, 3'd3, 3'd5, 5'd0); instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", ex_valid); end
        checks++; if (ex_op1 !== 16'h1234) begin errors++; $display("FAIL single_op1 got=%h exp=1234", ex_op1); end
        checks++; if (ex_op2 !== 16'h00FF) begin errors++; $display("FAIL single_op2 got=%h exp=00ff", ex_op2); end
        checks++; if ({ex_is_imm, ex_opcode, ex_src_addr, ex_dst_addr} !== {1'b0, 5'b00010, 3'd3, 3'd5}) begin
            errors++; $display("FAIL single_fields got=%b %b %0d %0d exp=0 00010 3 5", ex_is_imm, ex_opcode, ex_src_addr, ex_dst_addr); end
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL single_bubble got=%b exp=0", ex_valid); end
    endtask

    task automatic test_imm();
        wb_write(3'd2, 16'h2222);
        wb_write(3'd4, 16'h4444);
        instr_in = mk(IMM, 3'd2, 3'd4, 5'd7); instr_valid = 1'b1;
        step();
        checks++; if ({ex_valid, imm_pending} !== 2'b01) begin errors++; $display("FAIL imm_first got v=%b p=%b exp v=0 p=1", ex_valid, imm_pending); end
        instr_in = 16'hBEEF;
        step();
        instr_valid = 1'b0;
        checks++; if ({ex_valid, ex_is_imm, ex_imm} !== {2'b11, 16'hBEEF}) begin errors++; $display("FAIL imm_second got v=%b i=%b imm=%h exp 1 1 beef", ex_valid, ex_is_imm, ex_imm); end
        checks++; if ({ex_opcode, ex_src_addr, ex_dst_addr, ex_shamt} !== {IMM, 3'd2, 3'd4, 8'h87}) begin
            errors++; $display("FAIL imm_header got=%b %0d %0d %h exp=11000 2 4 87", ex_opcode, ex_src_addr, ex_dst_addr, ex_shamt); end
        checks++; if ({ex_op1, ex_op2, imm_pending} !== {16'h2222, 16'h4444, 1'b0}) begin errors++; $display("FAIL imm_ops got=%h %h p=%b exp=2222 4444 0", ex_op1, ex_op2, imm_pending); end
        // write-back while waiting for the immediate must be seen at issue
        instr_in = mk(IMM, 3'd2, 3'd4, 5'd0); instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        wb_write(3'd2, 16'h5555);
        checks++; if ({ex_valid, imm_pending} !== 2'b01) begin errors++; $display("FAIL imm_wait got v=%b p=%b exp v=0 p=1", ex_valid, imm_pending); end
        instr_in = 16'h1357; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        checks++; if ({ex_valid, ex_op1, ex_imm} !== {1'b1, 16'h5555, 16'h1357}) begin errors++; $display("FAIL imm_reread got v=%b op1=%h imm=%h exp 1 5555 1357", ex_valid, ex_op1, ex_imm); end
    endtask

    task automatic test_load_use();
        int issued;
        instr_in = mk(5'd3, 3'd3, 3'd5, 5'd0); instr_valid = 1'b1; load_use = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (fetch_hold !== 1'b1) begin errors++; $display("FAIL lu_hold%0d got=%b exp=1", i, fetch_hold); end
            step();
            checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble%0d got=%b exp=0", i, ex_valid); end
        end
        load_use = 1'b0;
        step();
        instr_valid = 1'b0;
        checks++; if ({ex_valid, ex_op1} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL lu_release got v=%b op1=%h exp 1 1234", ex_valid, ex_op1); end
        issued = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            issued += int'(ex_valid);
        end
        checks++; if (issued !== 0) begin errors++; $display("FAIL lu_once got=%0d extra issues exp=0", issued); end
    endtask

    task automatic test_flush_imm();
        instr_in = mk(IMM, 3'd1, 3'd1, 5'd0); instr_valid = 1'b1;
        step();
        instr_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if ({imm_pending, ex_valid, ex_is_imm} !== 3'b000) begin errors++; $display("FAIL flush_state got p=%b v=%b i=%b exp 0 0 0", imm_pending, ex_valid, ex_is_imm); end
        instr_in = 16'h0042; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        checks++; if ({ex_valid, ex_is_imm, ex_imm, ex_opcode, ex_dst_addr, ex_shamt} !== {2'b10, 16'h0, 5'd0, 3'd2, 8'h42}) begin
            errors++; $display("FAIL flush_next got v=%b i=%b imm=%h opc=%b rd=%0d sh=%h exp 1 0 0 0 2 42",
                               ex_valid, ex_is_imm, ex_imm, ex_opcode, ex_dst_addr, ex_shamt); end
    endtask

    task automatic test_collision();
        logic [15:0] exp_op1;
`ifdef DECODE_WB_BYPASS_EN
        exp_op1 = 16'hAAAA;
`else
        exp_op1 = 16'h0001;
`endif
        wb_write(3'd1, 16'h0001);
        wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'hAAAA;
        instr_in = mk(5'd2, 3'd1, 3'd0, 5'd0); instr_valid = 1'b1;
        step();
        wb_en = 1'b0;
        checks++; if ({ex_valid, ex_op1} !== {1'b1, exp_op1}) begin errors++; $display("FAIL collision got v=%b op1=%h exp 1 %h", ex_valid, ex_op1, exp_op1); end
        step();
        instr_valid = 1'b0;
        checks++; if (ex_op1 !== 16'hAAAA) begin errors++; $display("FAIL collision_after got=%h exp=aaaa", ex_op1); end
    endtask

    task automatic test_param();
        p_wb_en = 1'b1; p_wb_addr = 4'hF; p_wb_data = 32'hDEADBEEF;
        step();
        p_wb_en = 1'b0;
        p_instr = {5'd2, 4'd15, 4'd3, 19'd0}; p_valid = 1'b1;
        step();
        p_valid = 1'b0;
        checks++; if ({p_ex_valid, p_ex_op1} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL param_op1 got v=%b op1=%h exp 1 deadbeef", p_ex_valid, p_ex_op1); end
        checks++; if ({p_ex_src_addr, p_ex_dst_addr} !== {4'hF, 4'h3}) begin errors++; $display("FAIL param_addr got=%h %h exp f 3", p_ex_src_addr, p_ex_dst_addr); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst         = ($urandom_range(99) == 0);
            load_use    = ($urandom_range(99) < 15);
            flush       = ($urandom_range(99) < 10);
            instr_valid = ($urandom_range(99) < 70);
            instr_in    = 16'($urandom);
            if ($urandom_range(99) < 30) instr_in[15:11] = IMM;
            wb_en   = ($urandom_range(1) == 1);
            wb_addr = 3'($urandom);
            wb_data = 16'($urandom);
            #1;
            checks++; if (fetch_hold !== load_use) begin errors++; $display("FAIL rnd_hold n=%0d got=%b exp=%b", n, fetch_hold, load_use); end
            step();
            checks++; if ({ex_valid, imm_pending} !== {m_valid, m_pend}) begin
                errors++; $display("FAIL rnd_ctrl n=%0d got v=%b p=%b exp v=%b p=%b", n, ex_valid, imm_pending, m_valid, m_pend); end
            if (m_valid) begin
                checks++;
                if ({ex_opcode, ex_src_addr, ex_dst_addr, ex_op1, ex_op2, ex_imm, ex_shamt, ex_is_imm} !==
                    {m_opc, m_rs, m_rd, m_op1, m_op2, m_imm, m_sh, m_isimm}) begin
                    errors++;
                    $display("FAIL rnd_bundle n=%0d got %b %0d %0d %h %h %h %h %b exp %b %0d %0d %h %h %h %h %b", n,
                             ex_opcode, ex_src_addr, ex_dst_addr, ex_op1, ex_op2, ex_imm, ex_shamt, ex_is_imm,
                             m_opc, m_rs, m_rd, m_op1, m_op2, m_imm, m_sh, m_isimm);
                end
            end
        end
        rst = 1'b0; load_use = 1'b0; flush = 1'b0; instr_valid = 1'b0; wb_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr_in = '0; instr_valid = 1'b0; load_use = 1'b0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        p_instr = '0; p_valid = 1'b0; p_wb_en = 1'b0; p_wb_addr = '0; p_wb_data = '0;
        @(negedge clk);
        test_reset();
        test_single_decode();
        test_imm();
        test_load_use();
        test_flush_imm();
        test_collision();
        test_param();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
